// File: rtl/traffic_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// traffic_sequencer_pkg
// Shared definitions for the traffic sequencer and its bench: phase codes,
// dwell-count width, power-on dwell values and small phase helpers.
// ---------------------------------------------------------------------------
package traffic_sequencer_pkg;

    localparam int CNT_W = 3;

    typedef logic [CNT_W-1:0] cnt_t;

    typedef enum logic [1:0] {
        PH_NS_GREEN  = 2'b00,
        PH_NS_YELLOW = 2'b01,
        PH_EW_GREEN  = 2'b10,
        PH_EW_YELLOW = 2'b11
    } phase_t;

    localparam cnt_t CNT_ONE      = 3'd1;
    localparam cnt_t CNT_MAX      = 3'd7;
    localparam cnt_t DWELL_GREEN  = 3'd5;
    localparam cnt_t DWELL_YELLOW = 3'd2;

    function automatic phase_t next_phase(input phase_t p);
        phase_t n;
        case (p)
            PH_NS_GREEN:  n = PH_NS_YELLOW;
            PH_NS_YELLOW: n = PH_EW_GREEN;
            PH_EW_GREEN:  n = PH_EW_YELLOW;
            default:      n = PH_NS_GREEN;
        endcase
        return n;
    endfunction

    // Green phases have an even code.
    function automatic logic is_green(input phase_t p);
        return ~p[0];
    endfunction

    // A programmed dwell of zero behaves as one cycle.
    function automatic cnt_t eff_dwell(input cnt_t v);
        return (v == '0) ? CNT_ONE : v;
    endfunction

endpackage

// File: rtl/traffic_sequencer_dwell_counter.sv
// ---------------------------------------------------------------------------
// phase_dwell_counter
// Run-length counter for the current phase: loads 1 when the phase changes,
// otherwise increments on each enabled edge and saturates at CNT_MAX.
// Ports:
//   clk      - clock
//   rst      - asynchronous active-high reset (count -> 1)
//   i_en     - advance enable; count holds when low
//   i_load   - phase changes on this edge; restart count at 1
//   o_count  - cycles spent in the current phase, 1-based
// ---------------------------------------------------------------------------
module phase_dwell_counter
    import traffic_sequencer_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             i_en,
    input  logic             i_load,
    output logic [CNT_W-1:0] o_count
);

    cnt_t r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= CNT_ONE;
        end else if (i_en) begin
            if (i_load) begin
                r_count <= CNT_ONE;
            end else if (r_count != CNT_MAX) begin
                r_count <= r_count + CNT_ONE;
            end
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/traffic_sequencer.sv
// ---------------------------------------------------------------------------
// traffic_sequencer
// Four-phase traffic light sequencer with a programmable per-phase dwell
// table and a latched pedestrian request that can cut a green phase short
// once it has lasted MIN_GREEN cycles.
//
//   state        | meaning
//   -------------+------------------------------------------
//   PH_NS_GREEN  | north-south green, pedestrian cut allowed
//   PH_NS_YELLOW | north-south yellow, requests carried over
//   PH_EW_GREEN  | east-west green, pedestrian cut allowed
//   PH_EW_YELLOW | east-west yellow, requests carried over
//
// Ports:
//   clk            - clock
//   rst            - asynchronous active-high reset
//   i_en           - advance enable; phase and count freeze when low
//   i_ped_req      - pedestrian request pulse (latched)
//   i_cfg_we       - dwell-table write strobe
//   i_cfg_sel[1:0] - dwell-table index (phase code)
//   i_cfg_val[2:0] - dwell value in cycles (0 acts as 1)
//   o_phase[1:0]   - current phase code
//   o_count[2:0]   - cycles spent in the current phase, 1-based
//   o_ped_ack      - one-cycle pulse after a request is served
//   o_ped_pending  - request latched and not yet served
// ---------------------------------------------------------------------------
module traffic_sequencer
    import traffic_sequencer_pkg::*;
#(
    parameter int MIN_GREEN = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_en,
    input  logic             i_ped_req,
    input  logic             i_cfg_we,
    input  logic [1:0]       i_cfg_sel,
    input  logic [CNT_W-1:0] i_cfg_val,
    output logic [1:0]       o_phase,
    output logic [CNT_W-1:0] o_count,
    output logic             o_ped_ack,
    output logic             o_ped_pending
);

    localparam cnt_t MIN_GREEN_C = cnt_t'(MIN_GREEN);

    phase_t r_phase;
    phase_t w_phase_next;
    cnt_t   r_dwell [4];
    logic   r_ped_pending;
    logic   r_ped_ack;

    cnt_t   w_count;
    logic   w_dwell_done;
    logic   w_ped_cut;
    logic   w_advance;
    logic   w_serve;

    phase_dwell_counter u_dwell_counter (
        .clk     (clk),
        .rst     (rst),
        .i_en    (i_en),
        .i_load  (w_advance),
        .o_count (w_count)
    );

    // Advance decision uses the table as registered; a write this cycle
    // takes effect from the next cycle.
    always_comb begin
        w_dwell_done = (w_count >= eff_dwell(r_dwell[r_phase]));
        w_ped_cut    = is_green(r_phase) && r_ped_pending && (w_count >= MIN_GREEN_C);
        w_advance    = i_en && (w_dwell_done || w_ped_cut);
        // Any green exit with a request latched serves it, including a
        // natural dwell expiry.
        w_serve      = w_advance && is_green(r_phase) && r_ped_pending;
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_phase <= PH_NS_GREEN;
        end else begin
            r_phase <= w_phase_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_phase_next = r_phase;
        if (w_advance) begin
            w_phase_next = next_phase(r_phase);
        end
    end

    // Output logic
    always_comb begin
        o_phase       = r_phase;
        o_count       = w_count;
        o_ped_ack     = r_ped_ack;
        o_ped_pending = r_ped_pending;
    end

    // Request latch: a new request on the serving edge keeps it pending.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ped_pending <= 1'b0;
            r_ped_ack     <= 1'b0;
        end else begin
            r_ped_ack <= w_serve;
            if (i_ped_req) begin
                r_ped_pending <= 1'b1;
            end else if (w_serve) begin
                r_ped_pending <= 1'b0;
            end
        end
    end

    // Dwell table; writes register regardless of i_en.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_dwell[PH_NS_GREEN]  <= DWELL_GREEN;
            r_dwell[PH_NS_YELLOW] <= DWELL_YELLOW;
            r_dwell[PH_EW_GREEN]  <= DWELL_GREEN;
            r_dwell[PH_EW_YELLOW] <= DWELL_YELLOW;
        end else if (i_cfg_we) begin
            r_dwell[i_cfg_sel] <= i_cfg_val;
        end
    end

endmodule

// File: tb/tb_traffic_sequencer.sv
// ---------------------------------------------------------------------------
// tb_traffic_sequencer
// Directed bench for traffic_sequencer. Each step drives inputs, queues the
// state expected after the next rising edge, then pops and compares #1 later.
// ---------------------------------------------------------------------------
module tb_traffic_sequencer;
    import traffic_sequencer_pkg::*;

    logic       clk;
    logic       rst;
    logic       en;
    logic       ped;
    logic       we;
    logic [1:0] sel;
    logic [2:0] val;
    logic [1:0] phase;
    logic [2:0] count;
    logic       ack;
    logic       pend;

    typedef struct {
        logic [1:0] ph;
        logic [2:0] cnt;
        logic       ack;
        logic       pend;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    traffic_sequencer #(.MIN_GREEN(2)) dut (
        .clk           (clk),
        .rst           (rst),
        .i_en          (en),
        .i_ped_req     (ped),
        .i_cfg_we      (we),
        .i_cfg_sel     (sel),
        .i_cfg_val     (val),
        .o_phase       (phase),
        .o_count       (count),
        .o_ped_ack     (ack),
        .o_ped_pending (pend)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [2:0] obs, input logic [2:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic push(input logic [1:0] ph, input logic [2:0] cnt, input logic a, input logic p);
        exp_t e;
        e.ph   = ph;
        e.cnt  = cnt;
        e.ack  = a;
        e.pend = p;
        exp_q.push_back(e);
    endtask

    task automatic pop_check(input string tag);
        exp_t e;
        if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $error("FAIL %s: scoreboard empty, observed phase %0d count %0d", tag, phase, count);
        end else begin
            e = exp_q.pop_front();
            chk({tag, " phase"}, {1'b0, phase}, {1'b0, e.ph});
            chk({tag, " count"}, count, e.cnt);
            chk({tag, " ack"},   {2'b00, ack},  {2'b00, e.ack});
            chk({tag, " pend"},  {2'b00, pend}, {2'b00, e.pend});
        end
    endtask

    // One clock step; cfg strobe and ped_req are single-cycle pulses.
    task automatic cyc(input string tag, input logic e_en, input logic e_ped,
                       input logic [1:0] ph, input logic [2:0] cnt,
                       input logic a, input logic p);
        en  = e_en;
        ped = e_ped;
        push(ph, cnt, a, p);
        @(posedge clk);
        #1;
        ped = 1'b0;
        we  = 1'b0;
        pop_check(tag);
    endtask

    task automatic run(input string tag, input logic [1:0] ph, input int c0, input int c1, input logic p);
        for (int c = c0; c <= c1; c++) begin
            cyc(tag, 1'b1, 1'b0, ph, 3'(c), 1'b0, p);
        end
    endtask

    // Full default rotation from NS_GREEN count 1 back to NS_GREEN count 1.
    task automatic full_cycle(input string tag);
        exp_t seq[$];
        exp_t e;
        logic [1:0] phs [4];
        int   dw  [4];
        phs[0] = PH_NS_GREEN;  dw[0] = int'(DWELL_GREEN);
        phs[1] = PH_NS_YELLOW; dw[1] = int'(DWELL_YELLOW);
        phs[2] = PH_EW_GREEN;  dw[2] = int'(DWELL_GREEN);
        phs[3] = PH_EW_YELLOW; dw[3] = int'(DWELL_YELLOW);
        for (int p = 0; p < 4; p++) begin
            for (int c = 1; c <= dw[p]; c++) begin
                e.ph   = phs[p];
                e.cnt  = 3'(c);
                e.ack  = 1'b0;
                e.pend = 1'b0;
                seq.push_back(e);
            end
        end
        for (int k = 1; k <= seq.size(); k++) begin
            e = seq[k % seq.size()];
            cyc(tag, 1'b1, 1'b0, e.ph, e.cnt, 1'b0, 1'b0);
        end
    endtask

    initial begin
        rst = 1'b1;
        en  = 1'b0;
        ped = 1'b0;
        we  = 1'b0;
        sel = 2'd0;
        val = 3'd0;
        #12;
        push(PH_NS_GREEN, 3'd1, 1'b0, 1'b0);
        pop_check("reset");
        @(posedge clk);
        #1;
        rst = 1'b0;

        full_cycle("default");

        // Pedestrian cut of NS_GREEN after MIN_GREEN
        cyc("pedcut", 1, 1, PH_NS_GREEN,  3'd2, 1'b0, 1'b1);
        cyc("pedcut", 1, 0, PH_NS_YELLOW, 3'd1, 1'b1, 1'b0);
        cyc("pedcut", 1, 0, PH_NS_YELLOW, 3'd2, 1'b0, 1'b0);
        run("pedcut", PH_EW_GREEN, 1, 5, 1'b0);
        run("pedcut", PH_EW_YELLOW, 1, 2, 1'b0);
        cyc("pedcut", 1, 0, PH_NS_GREEN,  3'd1, 1'b0, 1'b0);

        // Request during yellow carries to EW_GREEN
        run("pedyel", PH_NS_GREEN, 2, 5, 1'b0);
        cyc("pedyel", 1, 0, PH_NS_YELLOW, 3'd1, 1'b0, 1'b0);
        cyc("pedyel", 1, 1, PH_NS_YELLOW, 3'd2, 1'b0, 1'b1);
        cyc("pedyel", 1, 0, PH_EW_GREEN,  3'd1, 1'b0, 1'b1);
        cyc("pedyel", 1, 0, PH_EW_GREEN,  3'd2, 1'b0, 1'b1);
        cyc("pedyel", 1, 0, PH_EW_YELLOW, 3'd1, 1'b1, 1'b0);
        cyc("pedyel", 1, 0, PH_EW_YELLOW, 3'd2, 1'b0, 1'b0);
        cyc("pedyel", 1, 0, PH_NS_GREEN,  3'd1, 1'b0, 1'b0);

        // EW_GREEN dwell programmed to 0 behaves as 1
        we = 1'b1; sel = 2'd2; val = 3'd0;
        cyc("zero", 1, 0, PH_NS_GREEN, 3'd2, 1'b0, 1'b0);
        run("zero", PH_NS_GREEN, 3, 5, 1'b0);
        run("zero", PH_NS_YELLOW, 1, 2, 1'b0);
        cyc("zero", 1, 0, PH_EW_GREEN,  3'd1, 1'b0, 1'b0);
        cyc("zero", 1, 0, PH_EW_YELLOW, 3'd1, 1'b0, 1'b0);
        cyc("zero", 1, 0, PH_EW_YELLOW, 3'd2, 1'b0, 1'b0);
        cyc("zero", 1, 0, PH_NS_GREEN,  3'd1, 1'b0, 1'b0);

        // Shrink active NS_GREEN entry below the running count
        run("shrink", PH_NS_GREEN, 2, 3, 1'b0);
        we = 1'b1; sel = 2'd0; val = 3'd1;
        cyc("shrink", 1, 0, PH_NS_GREEN,  3'd4, 1'b0, 1'b0);
        cyc("shrink", 1, 0, PH_NS_YELLOW, 3'd1, 1'b0, 1'b0);
        cyc("shrink", 1, 0, PH_NS_YELLOW, 3'd2, 1'b0, 1'b0);
        cyc("shrink", 1, 0, PH_EW_GREEN,  3'd1, 1'b0, 1'b0);
        cyc("shrink", 1, 0, PH_EW_YELLOW, 3'd1, 1'b0, 1'b0);
        cyc("shrink", 1, 0, PH_EW_YELLOW, 3'd2, 1'b0, 1'b0);
        cyc("shrink", 1, 0, PH_NS_GREEN,  3'd1, 1'b0, 1'b0);

        // Restore table while frozen; writes still register
        we = 1'b1; sel = 2'd0; val = 3'd5;
        cyc("restore", 0, 0, PH_NS_GREEN, 3'd1, 1'b0, 1'b0);
        we = 1'b1; sel = 2'd2; val = 3'd5;
        cyc("restore", 0, 0, PH_NS_GREEN, 3'd1, 1'b0, 1'b0);

        // Freeze at count 3 with a request latched, then cut on resume
        run("freeze", PH_NS_GREEN, 2, 3, 1'b0);
        cyc("freeze", 0, 1, PH_NS_GREEN, 3'd3, 1'b0, 1'b1);
        for (int i = 0; i < 9; i++) begin
            cyc("freeze", 0, 0, PH_NS_GREEN, 3'd3, 1'b0, 1'b1);
        end
        cyc("freeze", 1, 0, PH_NS_YELLOW, 3'd1, 1'b1, 1'b0);
        cyc("freeze", 1, 0, PH_NS_YELLOW, 3'd2, 1'b0, 1'b0);
        cyc("freeze", 1, 0, PH_EW_GREEN,  3'd1, 1'b0, 1'b0);

        // All entries 7: count climbs to 7 and restarts at 1 on the next phase
        for (int i = 0; i < 4; i++) begin
            we = 1'b1; sel = 2'(i); val = 3'd7;
            cyc("sat", 0, 0, PH_EW_GREEN, 3'd1, 1'b0, 1'b0);
        end
        run("sat", PH_EW_GREEN, 2, 7, 1'b0);
        run("sat", PH_EW_YELLOW, 1, 7, 1'b0);
        run("sat", PH_NS_GREEN, 1, 7, 1'b0);
        run("sat", PH_NS_YELLOW, 1, 7, 1'b0);
        cyc("sat", 1, 0, PH_EW_GREEN, 3'd1, 1'b0, 1'b0);

        // Asynchronous reset mid EW_GREEN with a request pending
        cyc("async", 1, 1, PH_EW_GREEN, 3'd2, 1'b0, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        push(PH_NS_GREEN, 3'd1, 1'b0, 1'b0);
        pop_check("async_rst");
        en  = 1'b1;
        ped = 1'b1;
        push(PH_NS_GREEN, 3'd1, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        pop_check("rst_override");
        rst = 1'b0;
        ped = 1'b0;

        // Table back to defaults after reset
        full_cycle("post_reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/traffic_sequencer.md
TRAFFIC_SEQUENCER -- requirements
Module: traffic_sequencer

Interface
REQ-001 Parameter: MIN_GREEN, default 2; minimum green dwell in cycles before a pedestrian request may cut green short.
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 en  input  1  advance enable; when low, phase and dwell count freeze.
REQ-005 ped_req  input  1  pedestrian request pulse; latched internally.
REQ-006 cfg_we  input  1  dwell-table write strobe.
REQ-007 cfg_sel  input  2  dwell-table index (phase code).
REQ-008 cfg_val  input  3  dwell value in cycles; 0 is treated as 1.
REQ-009 phase  output  2  current phase: 00 NS_GREEN, 01 NS_YELLOW, 10 EW_GREEN, 11 EW_YELLOW.
REQ-010 count  output  3  cycles spent in the current phase, 1-based.
REQ-011 ped_ack  output  1  one-cycle pulse when a latched pedestrian request is served.
REQ-012 ped_pending  output  1  latched request not yet served.

Function
REQ-013 Phases SHALL cycle strictly NS_GREEN -> NS_YELLOW -> EW_GREEN -> EW_YELLOW -> NS_GREEN; no other transition is legal.
REQ-014 The dwell counter SHALL load 1 on the edge that changes phase, and increment by 1 on each enabled edge that keeps the phase.
REQ-015 The count SHALL saturate at 7 and never wrap.
REQ-016 The dwell table SHALL hold four 3-bit entries, one per phase: 5 for green phases and 2 for yellow phases.
REQ-017 Effective dwell SHALL be max(entry, 1).
REQ-018 With en high, the phase SHALL advance on the edge where count >= effective dwell of the current phase.
- Each phase therefore lasts exactly its effective dwell in cycles.
REQ-019 With en high, in a green phase with ped_pending high and count >= MIN_GREEN, the phase SHALL advance to its yellow on the next edge, regardless of dwell.
REQ-020 ped_ack SHALL be high for exactly the cycle after a green-to-yellow transition that occurred while ped_pending was high.
- ped_pending SHALL clear on that same edge.
REQ-021 ped_req SHALL set ped_pending on the next edge.
- A ped_req coincident with a serving transition SHALL re-set ped_pending; set wins.
REQ-022 A cfg_we write SHALL update the entry on the next edge and be used from the following cycle.
- Writing the active phase's entry below the current count SHALL cause advance on the next enabled edge.
REQ-023 With en low: phase, count and the dwell table SHALL hold, except that ped_pending and cfg writes still register.
- ped_ack SHALL stay low.
REQ-024 Yellow phases SHALL ignore ped_pending; a pending request carries to the next green.

Reset
REQ-025 On rst, the following SHALL take effect asynchronously, and rst SHALL override all other inputs:
- phase = NS_GREEN, count = 1, ped_pending = 0, ped_ack = 0;
- dwell table = {5, 2, 5, 2}.
REQ-026 Deassertion mid-sequence SHALL resume from NS_GREEN with count 1 on the first enabled edge.

Structure
REQ-027 Phase codes, default dwell values and the count width (3) SHALL live in a shared package/header used by the sequencer and its bench.
REQ-028 The run-length dwell counter (load-1-on-change, increment-on-hold, saturate) SHALL be a separate sub-module, phase_dwell_counter.
- The phase FSM, request latch and dwell table SHALL stay in traffic_sequencer.

Verification
REQ-029 Default run: reset, then en=1 for 14 cycles -> phase sequence 00×5, 01×2, 10×5, 01-less 11×2; count runs 1..5, 1..2, 1..5, 1..2 exactly.
REQ-030 Pedestrian cut: ped_req pulsed at NS_GREEN count=1 -> advance to 01 on the edge after count=2; ped_ack=1 for one cycle; ped_pending=0 afterwards.
REQ-031 Request in yellow: ped_req during NS_YELLOW -> no ack in yellow; EW_GREEN lasts 2 cycles; then ped_ack pulses.
REQ-032 Reconfig/zero: write cfg_sel=10, cfg_val=0, then run -> EW_GREEN lasts 1 cycle. Write NS_GREEN=1 while at count=4 -> advance on the next edge.
REQ-033 Freeze/saturation: en=0 for 10 cycles at count=3 -> phase and count hold, ped_req is latched with no ack. With all entries 7 and en held, count reaches 7 and never wraps.
REQ-034 Async reset: assert rst mid EW_GREEN between clock edges -> outputs go to 00/1/0/0 immediately; the table returns to {5, 2, 5, 2}.
